div_seq: RTL and testbench

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_seq_pkg.sv | 32 +++
 rtl/div_seq_if.sv | 27 ++
 rtl/div_seq.sv | 126 ++++++++++++
 tb/tb_div_seq.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/div_seq_pkg.sv
// Purpose: shared constants and helpers for the sequential divider and its EX-stage user.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_seq_pkg;

  // Divider FSM encodings
  localparam logic [1:0] DIV_FREE    = 2'b00;
  localparam logic [1:0] DIV_BY_ZERO = 2'b01;
  localparam logic [1:0] DIV_ON      = 2'b10;
  localparam logic [1:0] DIV_END     = 2'b11;

  // Result handshake levels seen by EX
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  // Request levels driven by EX
  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP  = 1'b0;

  // ALU op codes that route an instruction to the divider
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  // Iteration counter value on the edge that performs the 32nd (final) step
  localparam logic [5:0] DIV_LAST_CNT = 6'd31;

  // Two's complement negate when en is set, pass-through otherwise
  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic en);
    return en ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_seq_if.sv
// Purpose: request/result bundle between the EX stage (master) and the divider (slave).
// Latency: n/a (wiring only).
// Backpressure: EX holds start_i until ready_o; busy_o is the stall request.
interface div_seq_if;

  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;

  // EX side: issues the operation and consumes the result
  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, busy_o
  );

  // Divider side
  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, busy_o
  );

endinterface

// File: rtl/div_seq.sv
// Purpose: 32-bit signed/unsigned restoring divider, one quotient bit per clock, {rem, quo} out.
// Latency: ready_o 33 edges after accept (2 edges for a zero divisor), no early exit.
// Backpressure: result held while start_i stays high; busy_o stalls EX; annul_i aborts in flight.
module div_seq
  import div_seq_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  div_seq_if.slave  div
);

  logic [1:0]  state;
  logic [5:0]  cnt;
  // [64:32] running remainder, [31:0] dividend bits shifting out / quotient bits shifting in.
  // After the final step the corrected {1'b0, rem, quo} is parked here until END releases it.
  logic [64:0] partial;
  logic [31:0] divisor;
  logic        quo_neg;
  logic        rem_neg;
  logic [63:0] result_q;
  logic        ready_q;

  // Operand magnitudes taken at accept
  logic        op1_neg;
  logic        op2_neg;
  logic [31:0] op1_abs;
  logic [31:0] op2_abs;

  // One restoring iteration
  logic [33:0] diff;
  logic [64:0] step_next;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  // Magnitude of each operand; unsigned mode leaves them untouched
  always_comb begin
    op1_neg = div.signed_div_i & div.opdata1_i[31];
    op2_neg = div.signed_div_i & div.opdata2_i[31];
    op1_abs = neg_if(div.opdata1_i, op1_neg);
    op2_abs = neg_if(div.opdata2_i, op2_neg);
  end

  // Shift-subtract step; the remainder always stays below the divisor so partial[64]
  // is zero and partial[64:31] is exactly the shifted-up remainder with a spare borrow bit.
  always_comb begin
    diff = partial[64:31] - {2'b00, divisor};
    if (diff[33]) begin
      step_next = {partial[63:0], 1'b0};
    end else begin
      step_next = {diff[32:0], partial[30:0], 1'b1};
    end
    quo_fix = neg_if(step_next[31:0],  quo_neg);
    rem_fix = neg_if(step_next[63:32], rem_neg);
  end

  // Divider FSM, iteration datapath and registered result
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DIV_FREE;
      cnt      <= 6'd0;
      partial  <= 65'd0;
      divisor  <= 32'd0;
      quo_neg  <= 1'b0;
      rem_neg  <= 1'b0;
      result_q <= 64'd0;
      ready_q  <= DIV_RESULT_NOT_READY;
    end else begin
      // Outputs are zero everywhere except while END holds a result for EX
      result_q <= 64'd0;
      ready_q  <= DIV_RESULT_NOT_READY;
      case (state)
        DIV_FREE: begin
          if (div.start_i == DIV_START && !div.annul_i) begin
            if (div.opdata2_i == 32'd0) begin
              state <= DIV_BY_ZERO;
            end else begin
              state   <= DIV_ON;
              cnt     <= 6'd0;
              partial <= {33'd0, op1_abs};
              divisor <= op2_abs;
              quo_neg <= op1_neg ^ op2_neg;
              rem_neg <= op1_neg;
            end
          end
        end
        DIV_BY_ZERO: begin
          if (div.annul_i) begin
            state <= DIV_FREE;
          end else begin
            state   <= DIV_END;
            partial <= 65'd0;
          end
        end
        DIV_ON: begin
          if (div.annul_i) begin
            state   <= DIV_FREE;
            cnt     <= 6'd0;
            partial <= 65'd0;
          end else if (cnt == DIV_LAST_CNT) begin
            state   <= DIV_END;
            cnt     <= 6'd0;
            partial <= {1'b0, rem_fix, quo_fix};
          end else begin
            cnt     <= cnt + 6'd1;
            partial <= step_next;
          end
        end
        default: begin
          // END: annul has no effect once the result is complete
          if (div.start_i == DIV_START) begin
            result_q <= partial[63:0];
            ready_q  <= DIV_RESULT_READY;
          end else begin
            state   <= DIV_FREE;
            partial <= 65'd0;
          end
        end
      endcase
    end
  end

  assign div.result_o = result_q;
  assign div.ready_o  = ready_q;
  assign div.busy_o   = (state == DIV_BY_ZERO) || (state == DIV_ON);

endmodule

// File: tb/tb_div_seq.sv
// Purpose: scoreboard bench for div_seq: spec vectors, zero divisor, annul, reset, random ops.
// Latency: checks ready_o 33 / 2 edges after accept.
// Backpressure: exercises start_i hold in END and annul in flight / in END.
module tb_div_seq;
  import div_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_seq_if dif ();

  div_seq dut (
    .clk (clk),
    .rst (rst),
    .div (dif)
  );

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference: {remainder, quotient}, zero for a zero divisor, wrap on the one overflow case
  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    logic [31:0] q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        sa = a;
        sb = b;
        q = sa / sb;
        r = sa % sb;
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    dif.signed_div_i = sgn;
    dif.opdata1_i    = a;
    dif.opdata2_i    = b;
    dif.annul_i      = 1'b0;
    dif.start_i      = DIV_START;
  endtask

  task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp);
    exp_q.push_back(exp);
    drive(sgn, a, b);
  endtask

  // Accept, wait for ready, check latency/result, hold start, then release
  task automatic collect(input string tag, input int exp_lat, input int hold, input logic annul_end);
    int n;
    logic leak, stable;
    logic [63:0] want;
    n = 0;
    leak = 1'b0;
    stable = 1'b1;
    tick();
    // Operands must not be resampled once accepted
    dif.opdata1_i    = $urandom;
    dif.opdata2_i    = $urandom;
    dif.signed_div_i = ~dif.signed_div_i;
    chk({tag, ".busy_run"}, 64'(dif.busy_o), 64'd1);
    while (dif.ready_o !== 1'b1 && n < 60) begin
      if (dif.result_o !== 64'd0) leak = 1'b1;
      tick();
      n++;
    end
    chk({tag, ".latency"}, 64'(n), 64'(exp_lat));
    chk({tag, ".zero_before_ready"}, 64'(leak), 64'd0);
    want = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
    chk({tag, ".result"}, dif.result_o, want);
    chk({tag, ".busy_end"}, 64'(dif.busy_o), 64'd0);
    for (int i = 0; i < hold; i++) begin
      dif.annul_i = annul_end && (i == 1);
      tick();
      if (dif.ready_o !== 1'b1 || dif.result_o !== want) stable = 1'b0;
    end
    dif.annul_i = 1'b0;
    if (hold > 0) chk({tag, ".held"}, 64'(stable), 64'd1);
    dif.start_i = DIV_STOP;
    tick();
    chk({tag, ".ready_drop"}, 64'(dif.ready_o), 64'd0);
    chk({tag, ".result_drop"}, dif.result_o, 64'd0);
  endtask

  initial begin
    logic        sgn;
    logic [31:0] a, b;
    logic        rose;

    rst = 1'b1;
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = 32'd0;
    dif.opdata2_i    = 32'd0;
    dif.start_i      = DIV_STOP;
    dif.annul_i      = 1'b0;
    repeat (3) tick();
    chk("rst.ready", 64'(dif.ready_o), 64'd0);
    chk("rst.result", dif.result_o, 64'd0);
    chk("rst.busy", 64'(dif.busy_o), 64'd0);
    rst = 1'b0;
    tick();

    issue(1'b0, 32'd100, 32'd7, {32'h0000_0002, 32'h0000_000E});
    collect("u100_7", 33, 2, 1'b0);

    issue(1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
    collect("s_m100_7", 33, 0, 1'b0);

    issue(1'b0, 32'd5, 32'd0, 64'd0);
    collect("u5_0", 2, 1, 1'b0);

    issue(1'b1, 32'h8000_0000, 32'd0, 64'd0);
    collect("s_min_0", 2, 0, 1'b0);

    // Annul at cnt=10: no result, then a fresh op
    drive(1'b0, 32'hFFFF_FFFF, 32'd3);
    tick();
    repeat (10) tick();
    chk("annul.busy", 64'(dif.busy_o), 64'd1);
    dif.annul_i = 1'b1;
    dif.start_i = DIV_STOP;
    tick();
    dif.annul_i = 1'b0;
    chk("annul.ready", 64'(dif.ready_o), 64'd0);
    chk("annul.result", dif.result_o, 64'd0);
    chk("annul.busy_free", 64'(dif.busy_o), 64'd0);
    rose = 1'b0;
    repeat (40) begin
      tick();
      if (dif.ready_o !== 1'b0) rose = 1'b1;
    end
    chk("annul.no_ready", 64'(rose), 64'd0);
    issue(1'b0, 32'd9, 32'd2, {32'd1, 32'd4});
    collect("u9_2", 33, 0, 1'b0);

    // Overflow case, held 5 cycles with annul pulsed in END
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});
    collect("s_min_m1", 33, 5, 1'b1);

    // Reset at cnt=20
    drive(1'b0, 32'd100, 32'd7);
    tick();
    repeat (20) tick();
    rst = 1'b1;
    dif.start_i = DIV_STOP;
    tick();
    chk("midrst.ready", 64'(dif.ready_o), 64'd0);
    chk("midrst.result", dif.result_o, 64'd0);
    chk("midrst.busy", 64'(dif.busy_o), 64'd0);
    rst = 1'b0;
    issue(1'b0, 32'd100, 32'd7, {32'h0000_0002, 32'h0000_000E});
    collect("post_rst", 33, 0, 1'b0);

    // Boundary and random operands against the reference model
    issue(1'b0, 32'hFFFF_FFFF, 32'd1, model(1'b0, 32'hFFFF_FFFF, 32'd1));
    collect("u_max_1", 33, 0, 1'b0);
    issue(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, model(1'b1, 32'h7FFF_FFFF, 32'h8000_0000));
    collect("s_max_min", 33, 0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = (i == 5) ? 32'd0 : ((i % 2) ? $urandom : 32'($urandom_range(1, 300)));
      if (b != 32'd0 && sgn && (i % 3 == 0)) b = -b;
      issue(sgn, a, b, model(sgn, a, b));
      collect($sformatf("rnd%0d", i), (b == 32'd0) ? 2 : 33, i % 3, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
